// File: rtl/pulse_frame_decoder.sv
// Receive-side decoder for the dual-pulse motor frame: synchronizes PWM_IN, locks to the
// inter-frame gap and measures both pulse widths. Define PULSE_DECODER_GLITCH_FILTER_EN for the input filter.
module pulse_frame_decoder #(
  parameter int CNT_W     = 21,
  parameter int SYNC_MIN  = 200000,
  parameter int GAP_MIN   = 100000,
  parameter int GAP_MAX   = 120000,
  parameter int PULSE_MAX = 400000,
  parameter int FILT_LEN  = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PWM_IN,
  output logic [CNT_W-1:0] PULSE1_W,
  output logic [CNT_W-1:0] PULSE2_W,
  output logic             VALID,
  output logic             FRAME_ERR,
  output logic             LOCKED,
  output logic [7:0]       ERR_CNT
);

  typedef enum logic [2:0] {
    ST_UNSYNC,
    ST_ARMED,
    ST_P1,
    ST_GAP,
    ST_P2,
    ST_TAIL
  } state_t;

  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] SYNC_LIM = CNT_W'(SYNC_MIN - 1);
  localparam logic [CNT_W-1:0] GAP_LO   = CNT_W'(GAP_MIN - 1);
  localparam logic [CNT_W-1:0] GAP_HI   = CNT_W'(GAP_MAX - 1);
  localparam logic [CNT_W-1:0] GAP_TO   = CNT_W'(GAP_MAX);
  localparam logic [CNT_W-1:0] PULSE_TO = CNT_W'(PULSE_MAX);

  if (FILT_LEN < 1) begin : g_filt_len_chk
    $error("FILT_LEN must be at least 1");
  end

  logic             sync1_q, sync2_q;
  logic             line, line_prev_q;
  logic [1:0]       warm_q, warm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] p1_q, p1_d;
  logic [CNT_W-1:0] pulse1_w_q, pulse1_w_d;
  logic [CNT_W-1:0] pulse2_w_q, pulse2_w_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             locked_q, locked_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             edge_det, rise, fall;
  logic             err, publish, latch_p1, lock_set;

`ifdef PULSE_DECODER_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  logic          filt_q, filt_d;
  logic [FW-1:0] stab_q, stab_d;

  // Line follows the synchronizer only after FILT_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    stab_d = '0;
    if (sync2_q != filt_q) begin
      if (stab_q == FW'(FILT_LEN - 1)) filt_d = sync2_q;
      else stab_d = stab_q + FW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      filt_q <= 1'b0;
      stab_q <= '0;
    end else begin
      filt_q <= filt_d;
      stab_q <= stab_d;
    end
  end

  assign line = filt_q;
`else
  assign line = sync2_q;
`endif

  assign edge_det = line ^ line_prev_q;
  assign rise     = edge_det & line;
  assign fall     = edge_det & ~line;
  assign warm_d   = {warm_q[0], 1'b1};

  // Counter is held until the synchronizer carries real samples after reset.
  always_comb begin
    if (!warm_q[1] || edge_det) cnt_d = '0;
    else if (cnt_q == CNT_SAT)  cnt_d = cnt_q;
    else                        cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_UNSYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    err      = 1'b0;
    publish  = 1'b0;
    latch_p1 = 1'b0;
    lock_set = 1'b0;
    case (state_q)
      ST_UNSYNC: begin
        if (!line && !edge_det && cnt_q >= SYNC_LIM) begin
          state_d  = ST_ARMED;
          lock_set = 1'b1;
        end
      end
      ST_ARMED: begin
        if (rise) state_d = ST_P1;
      end
      ST_P1: begin
        if (fall) begin
          state_d  = ST_GAP;
          latch_p1 = 1'b1;
        end else if (line && cnt_q >= PULSE_TO) begin
          err = 1'b1;
        end
      end
      ST_GAP: begin
        if (rise) begin
          if (cnt_q >= GAP_LO && cnt_q <= GAP_HI) state_d = ST_P2;
          else                                    err     = 1'b1;
        end else if (!line && cnt_q > GAP_TO) begin
          err = 1'b1;
        end
      end
      ST_P2: begin
        if (fall) begin
          state_d = ST_TAIL;
          publish = 1'b1;
        end else if (line && cnt_q >= PULSE_TO) begin
          err = 1'b1;
        end
      end
      ST_TAIL: begin
        if (rise)                                  err     = 1'b1;
        else if (!edge_det && cnt_q >= SYNC_LIM)   state_d = ST_ARMED;
      end
      default: state_d = ST_UNSYNC;
    endcase
    if (err) state_d = ST_UNSYNC;
  end

  // Widths are only ever overwritten by a complete good frame.
  always_comb begin
    p1_d       = latch_p1 ? cnt_q + CNT_W'(1) : p1_q;
    pulse1_w_d = pulse1_w_q;
    pulse2_w_d = pulse2_w_q;
    if (publish) begin
      pulse1_w_d = p1_q;
      pulse2_w_d = cnt_q + CNT_W'(1);
    end
    valid_d     = publish;
    frame_err_d = err;
    locked_d    = locked_q;
    if (lock_set) locked_d = 1'b1;
    if (err)      locked_d = 1'b0;
    err_cnt_d = err_cnt_q;
    if (err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      line_prev_q <= 1'b0;
      warm_q      <= '0;
      cnt_q       <= '0;
      p1_q        <= '0;
      pulse1_w_q  <= '0;
      pulse2_w_q  <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      locked_q    <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      sync1_q     <= PWM_IN;
      sync2_q     <= sync1_q;
      line_prev_q <= line;
      warm_q      <= warm_d;
      cnt_q       <= cnt_d;
      p1_q        <= p1_d;
      pulse1_w_q  <= pulse1_w_d;
      pulse2_w_q  <= pulse2_w_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      locked_q    <= locked_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign PULSE1_W  = pulse1_w_q;
  assign PULSE2_W  = pulse2_w_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = frame_err_q;
  assign LOCKED    = locked_q;
  assign ERR_CNT   = err_cnt_q;

endmodule

// File: doc/pulse_frame_decoder.md
Name: pulse_frame_decoder

Overview:
- Receive-side counterpart of the dual-pulse motor command stream: one 11 ms frame carries pulse 1 (left motor), a 1.1 ms holdoff, then pulse 2 (right motor).
- Synchronizes the serial PWM line, locks to frame boundaries and measures both pulse widths in CLK cycles (100 MHz).
- Publishes each good frame with a one-cycle strobe; flags malformed frames.
- Sits at the motor-controller-side input, or in loopback for self-test of the transmitter.

Parameters:
- CNT_W, 21, width of all cycle counters and width outputs
- SYNC_MIN, 200000, minimum low time (2 ms) treated as inter-frame gap
- GAP_MIN, 100000, minimum legal low time between pulse 1 and pulse 2
- GAP_MAX, 120000, maximum legal low time between pulse 1 and pulse 2
- PULSE_MAX, 400000, maximum legal high time of either pulse (4 ms)
- FILT_LEN, 8, glitch filter stability length in cycles (only used with the optional feature)

Ports:
- CLK  in  1  system clock, 100 MHz
- RST_N  in  1  asynchronous active-low reset
- PWM_IN  in  1  asynchronous serial pulse stream
- PULSE1_W  out  CNT_W  high width of pulse 1 in cycles, last good frame
- PULSE2_W  out  CNT_W  high width of pulse 2 in cycles, last good frame
- VALID  out  1  one-cycle strobe: new good frame published
- FRAME_ERR  out  1  one-cycle strobe: malformed frame discarded
- LOCKED  out  1  level: frame sync acquired
- ERR_CNT  out  8  saturating count of FRAME_ERR events

Behaviour:
- Reset (RST_N low, asynchronous): all outputs 0, state UNSYNC, counters 0, synchronizer flops 0. Reset mid-frame abandons the frame with no strobe.
- Input path: 2-flop synchronizer. "Line" below means the synchronized value; widths count cycles of line high.
- Single counter cnt is cleared on every line edge and otherwise increments, saturating at 2^CNT_W-1.
- States and transitions:
  - UNSYNC: line low with cnt >= SYNC_MIN-1 -> ARMED, LOCKED<=1.
  - ARMED: on rising edge -> P1.
  - P1 (line high): on falling edge, latch p1 = cnt+1 -> GAP. If cnt reaches PULSE_MAX -> error.
  - GAP (line low): on rising edge, check gap length in [GAP_MIN, GAP_MAX]. In range -> P2; out of range -> error. If cnt exceeds GAP_MAX while low -> error.
  - P2 (line high): on falling edge, PULSE1_W<=p1, PULSE2_W<=cnt+1, VALID<=1, then -> TAIL. If cnt reaches PULSE_MAX -> error.
  - TAIL (line low): at cnt = SYNC_MIN-1 -> ARMED. A rising edge before that -> error.
- Error action: FRAME_ERR<=1 for one cycle, ERR_CNT+1 (saturates at 255), LOCKED<=0, -> UNSYNC. PULSE1_W and PULSE2_W are left unchanged.
- Latency: VALID rises exactly 3 CLK cycles after the PWM_IN falling edge of pulse 2 (2 synchronizer stages + 1 register). Width outputs update in the same cycle as VALID.
- VALID and FRAME_ERR are never high in the same cycle.
- A transmitter pulse of value w appears high for w+1 cycles. The decoder reports measured width as is; no correction.
- Line stuck high in UNSYNC or ARMED: no strobe. In ARMED, the stuck-high line is handled as P1 and times out at PULSE_MAX.

Optional Feature:
- Macro: PULSE_DECODER_GLITCH_FILTER_EN.
- Defined: after the synchronizer, the filtered line changes only once the raw synchronized value has been stable for FILT_LEN consecutive cycles. Measured widths are unchanged, because both edges are delayed equally. Latency becomes 3+FILT_LEN cycles. Pulses shorter than FILT_LEN cycles are ignored.
- Not defined: the synchronizer output drives the state machine directly, and any 1-cycle glitch is treated as an edge.

Test Plan:
- Reset, hold PWM_IN low 2.5 ms -> LOCKED=1 at 200002 cycles after RST_N release, no strobes.
- Locked; frame: high 150001, low 109999, high 150001, low 11 ms -> VALID once 3 cycles after 2nd falling edge, PULSE1_W=PULSE2_W=150001.
- Frames with pulse1=100001, pulse2=200001 repeated 3 times -> 3 VALID strobes, widths 100001/200001, ERR_CNT=0.
- Gap of 50000 cycles between pulses -> FRAME_ERR once, LOCKED=0, ERR_CNT=1, widths keep previous values; relock after the next 2 ms low period.
- PWM_IN stuck high 5 ms after lock -> FRAME_ERR at PULSE_MAX, no VALID; assert RST_N low mid-pulse -> all outputs 0 immediately.
- With PULSE_DECODER_GLITCH_FILTER_EN: 3-cycle low glitch inside pulse 1 -> VALID, PULSE1_W unaffected. Without the macro: the same stimulus -> FRAME_ERR.
